// File: rtl/data_mem_param.sv
// data_mem_param: parametrised synchronous data memory with byte enables,
// registered read plus valid strobe, write-first collisions, out-of-range
// flag and a post-reset sweep that loads INIT_VAL into every word.
module data_mem_param #(
    parameter int unsigned          DATA_W   = 16,
    parameter int unsigned          ADDR_W   = 3,
    parameter int unsigned          DEPTH    = 8,
    parameter logic [DATA_W-1:0]    INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sig_mem_write,
    input  logic                  sig_mem_read,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   byte_en,
    input  logic [DATA_W-1:0]     write_data,
    output logic [DATA_W-1:0]     read_data_out,
    output logic                  read_valid,
    output logic                  addr_err,
    output logic                  busy
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CMP_W = ADDR_W + 1;
    localparam logic [CMP_W-1:0] DEPTH_C  = CMP_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        S_INIT,
        S_READY
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    w_cnt_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic                r_addr_err;
    logic                r_busy;

    logic [DATA_W-1:0]   w_rd_data_nxt;
    logic                w_rd_valid_nxt;
    logic                w_addr_err_nxt;
    logic                w_busy_nxt;

    logic                w_in_range;
    logic [IDX_W-1:0]    w_idx;
    logic [DATA_W-1:0]   w_old;
    logic [DATA_W-1:0]   w_merged;

    logic                w_mem_we;
    logic [IDX_W-1:0]    w_mem_idx;
    logic [DATA_W-1:0]   w_mem_wdata;

    // Address decode; the extra MSB keeps the unsigned compare exact when DEPTH == 2**ADDR_W
    assign w_in_range = ({1'b0, addr} < DEPTH_C);
    assign w_idx      = IDX_W'(addr);
    assign w_old      = r_mem[w_idx];

    // Byte-lane merge of store data over the current word (also the write-first read value)
    always_comb begin
        w_merged = w_old;
        for (int k = 0; k < NB; k++) begin
            if (byte_en[k]) begin
                w_merged[8*k +: 8] = write_data[8*k +: 8];
            end
        end
    end

    // Next-state, output and array-port decode
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_busy_nxt     = 1'b0;
        w_rd_valid_nxt = 1'b0;
        w_addr_err_nxt = 1'b0;
        w_rd_data_nxt  = r_rd_data;
        w_mem_we       = 1'b0;
        w_mem_idx      = w_idx;
        w_mem_wdata    = w_merged;

        if (!rst) begin
            case (r_state)
                S_INIT: begin
                    w_mem_we    = 1'b1;
                    w_mem_idx   = r_cnt;
                    w_mem_wdata = INIT_VAL;
                    w_cnt_nxt   = r_cnt + IDX_W'(1);
                    w_busy_nxt  = 1'b1;
                    if (r_cnt == LAST_IDX) begin
                        w_state_nxt = S_READY;
                        w_busy_nxt  = 1'b0;
                    end
                end
                S_READY: begin
                    if (sig_mem_write || sig_mem_read) begin
                        if (w_in_range) begin
                            w_mem_we = sig_mem_write;
                            if (sig_mem_read) begin
                                w_rd_data_nxt  = sig_mem_write ? w_merged : w_old;
                                w_rd_valid_nxt = 1'b1;
                            end
                        end else begin
                            w_addr_err_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_INIT;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            endcase
        end
    end

    // State and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_INIT;
            r_cnt      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_addr_err <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_addr_err <= w_addr_err_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Storage array; untouched while rst is high
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    assign read_data_out = r_rd_data;
    assign read_valid    = r_rd_valid;
    assign addr_err      = r_addr_err;
    assign busy          = r_busy;

endmodule

// File: tb/tb_data_mem_param.sv
// Directed bench for data_mem_param: default instance (DEPTH=8) and a
// DEPTH=6 instance sharing the same stimulus.
module tb_data_mem_param;

    logic        clk;
    logic        rst;
    logic        wr;
    logic        rd;
    logic [2:0]  addr;
    logic [1:0]  be;
    logic [15:0] wdata;

    logic [15:0] rdata8, rdata6;
    logic        rvalid8, rvalid6;
    logic        aerr8, aerr6;
    logic        busy8, busy6;

    int n_cmp  = 0;
    int n_fail = 0;

    data_mem_param u_dut (
        .clk(clk), .rst(rst), .sig_mem_write(wr), .sig_mem_read(rd),
        .addr(addr), .byte_en(be), .write_data(wdata),
        .read_data_out(rdata8), .read_valid(rvalid8),
        .addr_err(aerr8), .busy(busy8)
    );

    data_mem_param #(.DEPTH(6)) u_dut6 (
        .clk(clk), .rst(rst), .sig_mem_write(wr), .sig_mem_read(rd),
        .addr(addr), .byte_en(be), .write_data(wdata),
        .read_data_out(rdata6), .read_valid(rvalid6),
        .addr_err(aerr6), .busy(busy6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic w, input logic r, input logic [2:0] a,
                       input logic [1:0] b, input logic [15:0] d);
        wr = w; rd = r; addr = a; be = b; wdata = d;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [15:0] exp6 [6];

    initial begin
        rst = 1'b1;
        drv(1'b0, 1'b0, 3'd0, 2'b00, 16'h0000);

        // 1. reset for two cycles, then sweep
        tick(); tick();
        check("rst_busy",   32'(busy8),   32'd1);
        check("rst_valid",  32'(rvalid8), 32'd0);
        check("rst_err",    32'(aerr8),   32'd0);
        check("rst_rdata",  32'(rdata8),  32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("sweep_busy8_%0d", i), 32'(busy8), 32'd1);
            check($sformatf("sweep_busy6_%0d", i), 32'(busy6), (i < 6) ? 32'd1 : 32'd0);
            tick();
        end
        check("sweep_done", 32'(busy8), 32'd0);
        for (int a = 0; a < 8; a++) begin
            drv(1'b0, 1'b1, 3'(a), 2'b00, 16'h0000);
            tick();
            check($sformatf("init_rd_%0d", a), 32'(rdata8), 32'd0);
            check($sformatf("init_vld_%0d", a), 32'(rvalid8), 32'd1);
        end
        drv(1'b0, 1'b0, 3'd0, 2'b00, 16'h0000);
        tick();
        check("idle_vld", 32'(rvalid8), 32'd0);

        // 2. full-word write then read
        drv(1'b1, 1'b0, 3'd6, 2'b11, 16'd55); tick();
        check("wr_no_vld", 32'(rvalid8), 32'd0);
        drv(1'b0, 1'b1, 3'd6, 2'b00, 16'h0000); tick();
        check("rd6_data", 32'(rdata8), 32'd55);
        check("rd6_vld",  32'(rvalid8), 32'd1);

        // 3. partial writes
        drv(1'b1, 1'b0, 3'd2, 2'b11, 16'hABCD); tick();
        drv(1'b1, 1'b0, 3'd2, 2'b01, 16'h1234); tick();
        drv(1'b0, 1'b1, 3'd2, 2'b00, 16'h0000); tick();
        check("part_lo", 32'(rdata8), 32'h0000AB34);
        drv(1'b1, 1'b0, 3'd2, 2'b10, 16'h5600); tick();
        drv(1'b0, 1'b1, 3'd2, 2'b00, 16'h0000); tick();
        check("part_hi", 32'(rdata8), 32'h00005634);
        drv(1'b1, 1'b0, 3'd2, 2'b00, 16'hFFFF); tick();
        drv(1'b0, 1'b1, 3'd2, 2'b00, 16'h0000); tick();
        check("be_zero", 32'(rdata8), 32'h00005634);

        // 4. collisions are write-first
        drv(1'b1, 1'b1, 3'd0, 2'b11, 16'd55); tick();
        check("coll_data", 32'(rdata8), 32'd55);
        check("coll_vld",  32'(rvalid8), 32'd1);
        drv(1'b1, 1'b1, 3'd2, 2'b01, 16'h00FF); tick();
        check("coll_part", 32'(rdata8), 32'h000056FF);
        drv(1'b0, 1'b1, 3'd0, 2'b00, 16'h0000); tick();
        check("coll_later", 32'(rdata8), 32'd55);

        // 6. reset mid-sweep, writes while busy ignored, idle hold
        drv(1'b0, 1'b0, 3'd0, 2'b00, 16'h0000);
        rst = 1'b1; tick();
        rst = 1'b0; tick(); tick(); tick();
        check("mid_busy", 32'(busy8), 32'd1);
        rst = 1'b1; tick();
        check("rerst_rdata", 32'(rdata8), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("resweep_busy_%0d", i), 32'(busy8), 32'd1);
            drv(1'b1, 1'b1, 3'd3, 2'b11, 16'hFFFF);
            tick();
            check($sformatf("busy_no_vld_%0d", i), 32'(rvalid8), 32'd0);
        end
        check("resweep_done", 32'(busy8), 32'd0);
        drv(1'b0, 1'b1, 3'd3, 2'b00, 16'h0000); tick();
        check("busy_wr_ignored", 32'(rdata8), 32'd0);
        check("busy_wr_vld",     32'(rvalid8), 32'd1);
        drv(1'b0, 1'b1, 3'd0, 2'b00, 16'h0000); tick();
        check("resweep_clr0", 32'(rdata8), 32'd0);
        drv(1'b1, 1'b0, 3'd4, 2'b11, 16'h1357); tick();
        drv(1'b0, 1'b1, 3'd4, 2'b00, 16'h0000); tick();
        check("hold_setup", 32'(rdata8), 32'h00001357);
        drv(1'b0, 1'b0, 3'd4, 2'b00, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold_data_%0d", i), 32'(rdata8), 32'h00001357);
            check($sformatf("hold_vld_%0d", i),  32'(rvalid8), 32'd0);
        end

        // 5. out-of-range on the DEPTH=6 instance
        drv(1'b1, 1'b0, 3'd5, 2'b11, 16'hBEEF); tick();
        drv(1'b0, 1'b1, 3'd5, 2'b00, 16'h0000); tick();
        check("oor_setup", 32'(rdata6), 32'h0000BEEF);
        drv(1'b0, 1'b1, 3'd7, 2'b00, 16'h0000); tick();
        check("oor_rd_err",   32'(aerr6),   32'd1);
        check("oor_rd_vld",   32'(rvalid6), 32'd0);
        check("oor_rd_hold",  32'(rdata6),  32'h0000BEEF);
        check("full_no_err",  32'(aerr8),   32'd0);
        check("full_rd7_vld", 32'(rvalid8), 32'd1);
        drv(1'b0, 1'b0, 3'd0, 2'b00, 16'h0000); tick();
        check("oor_err_pulse", 32'(aerr6), 32'd0);
        drv(1'b1, 1'b0, 3'd6, 2'b11, 16'hFFFF); tick();
        check("oor_wr_err", 32'(aerr6), 32'd1);
        drv(1'b0, 1'b0, 3'd0, 2'b00, 16'h0000); tick();
        // DEPTH=6 finished its sweep two cycles early and accepted the
        // FFFF write to addr 3 issued while the DEPTH=8 instance was busy
        exp6[0] = 16'h0000; exp6[1] = 16'h0000; exp6[2] = 16'h0000;
        exp6[3] = 16'hFFFF; exp6[4] = 16'h1357; exp6[5] = 16'hBEEF;
        for (int a = 0; a < 6; a++) begin
            drv(1'b0, 1'b1, 3'(a), 2'b00, 16'h0000);
            tick();
            check($sformatf("oor_word_%0d", a), 32'(rdata6), 32'(exp6[a]));
        end
        drv(1'b0, 1'b0, 3'd0, 2'b00, 16'h0000);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
